mealy_seq_detector: RTL and testbench



---
 rtl/seqdet_pkg.sv | 36 +++
 rtl/sat_counter.sv | 41 ++++
 rtl/mealy_seq_detector.sv | 97 +++++++++
 tb/tb_mealy_seq_detector.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/seqdet_pkg.sv
// Shared helpers for serial pattern detectors: state-width sizing and the
// KMP-style next-state construction evaluated at elaboration time.
package seqdet_pkg;

  localparam int SEQDET_MAX_LEN = 32;

  function automatic int seqdet_sw(int len);
    return (len < 2) ? 1 : $clog2(len);
  endfunction

  // Longest prefix of pattern that is a proper suffix of (first s pattern bits, b).
  function automatic int seqdet_ns(logic [31:0] pattern, int len, int s, logic b);
    int   best;
    int   pos;
    logic cur;
    bit   ok;
    best = 0;
    for (int k = 1; k < len; k++) begin
      if (k <= s + 1) begin
        ok = 1'b1;
        for (int j = 0; j < k; j++) begin
          pos = s + 1 - k + j;
          cur = (pos == s) ? b : pattern[5'(len - 1 - pos)];
          if (cur != pattern[5'(len - 1 - j)]) ok = 1'b0;
        end
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  function automatic int seqdet_border(logic [31:0] pattern, int len);
    return seqdet_ns(pattern, len, len - 1, pattern[0]);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with sticky saturation flag; a clear in the same
// cycle as an increment yields a count of one.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         sat
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         sat_q, sat_d;

  always_comb begin
    cnt_d = clr ? '0 : cnt_q;
    sat_d = clr ? 1'b0 : sat_q;
    if (inc && (cnt_d != '1)) begin
      cnt_d = cnt_d + W'(1);
    end
    if (cnt_d == '1) begin
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign cnt = cnt_q;
  assign sat = sat_q;

endmodule

// File: rtl/mealy_seq_detector.sv
// Parametrised Mealy detector for a LEN-bit serial pattern with optional
// overlap, a registered match copy and a saturating match counter.
module mealy_seq_detector
  import seqdet_pkg::*;
#(
  parameter int             LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b1011,
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = 8,
  localparam int            SW      = seqdet_sw(LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             din,
  input  logic             clr_cnt,
  output logic             match,
  output logic             match_r,
  output logic [SW-1:0]    state,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int            NS_DEPTH = 1 << SW;
  localparam int            BORDER   = seqdet_border(32'(PATTERN), LEN);
  localparam int            FULL_NS  = OVERLAP ? BORDER : 0;
  localparam logic [SW-1:0] LAST     = SW'(LEN - 1);

  if (LEN < 2 || LEN > SEQDET_MAX_LEN) begin : g_bad_len
    $error("mealy_seq_detector: LEN must be in 2..32");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("mealy_seq_detector: CNT_W must be at least 1");
  end

  logic [SW-1:0] ns0_tab [NS_DEPTH];
  logic [SW-1:0] ns1_tab [NS_DEPTH];

  // Unreachable encodings map to state 0 so a corrupted state self-recovers.
  for (genvar gi = 0; gi < NS_DEPTH; gi++) begin : g_ns
    if (gi < LEN) begin : g_live
      localparam logic EXP_B = PATTERN[LEN-1-gi];
      localparam bit   IS_LAST = (gi == LEN - 1);
      localparam int   NS0 = (IS_LAST && !EXP_B) ? FULL_NS
                                                 : seqdet_ns(32'(PATTERN), LEN, gi, 1'b0);
      localparam int   NS1 = (IS_LAST && EXP_B) ? FULL_NS
                                                : seqdet_ns(32'(PATTERN), LEN, gi, 1'b1);
      assign ns0_tab[gi] = SW'(NS0);
      assign ns1_tab[gi] = SW'(NS1);
    end else begin : g_dead
      assign ns0_tab[gi] = '0;
      assign ns1_tab[gi] = '0;
    end
  end

  logic [SW-1:0] state_q, state_d;
  logic          match_r_q;
  logic          state_ok;

  assign state_ok = (state_q <= LAST);

  always_comb begin
    state_d = state_q;
    match   = 1'b0;
    if (!state_ok) begin
      state_d = '0;
    end else if (en) begin
      state_d = din ? ns1_tab[state_q] : ns0_tab[state_q];
      match   = rst_n && (state_q == LAST) && (din == PATTERN[0]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= '0;
      match_r_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      match_r_q <= match;
    end
  end

  assign state   = state_q;
  assign match_r = match_r_q;

  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (match),
    .clr  (clr_cnt),
    .cnt  (match_cnt),
    .sat  (cnt_sat)
  );

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Scoreboard bench: the driver pushes hand-computed expectations per cycle,
// a negedge monitor pops and compares against the addressed instance.
module tb_mealy_seq_detector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_v [4];
  logic en_v  [4];
  logic din_v [4];
  logic clr_v [4];

  // 0: 1011 overlap, 1: 1011 no overlap, 2: 1101 overlap, 3: 1011 overlap CNT_W=2
  logic [1:0] st_0, st_1, st_2, st_3;
  logic       m_0, m_1, m_2, m_3;
  logic       mr_0, mr_1, mr_2, mr_3;
  logic [7:0] cnt_0, cnt_1, cnt_2;
  logic [1:0] cnt_3;
  logic       sat_0, sat_1, sat_2, sat_3;

  mealy_seq_detector #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_a (
    .clk(clk), .rst_n(rst_v[0]), .en(en_v[0]), .din(din_v[0]), .clr_cnt(clr_v[0]),
    .match(m_0), .match_r(mr_0), .state(st_0), .match_cnt(cnt_0), .cnt_sat(sat_0));
  mealy_seq_detector #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_b (
    .clk(clk), .rst_n(rst_v[1]), .en(en_v[1]), .din(din_v[1]), .clr_cnt(clr_v[1]),
    .match(m_1), .match_r(mr_1), .state(st_1), .match_cnt(cnt_1), .cnt_sat(sat_1));
  mealy_seq_detector #(.LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(8)) u_c (
    .clk(clk), .rst_n(rst_v[2]), .en(en_v[2]), .din(din_v[2]), .clr_cnt(clr_v[2]),
    .match(m_2), .match_r(mr_2), .state(st_2), .match_cnt(cnt_2), .cnt_sat(sat_2));
  mealy_seq_detector #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) u_d (
    .clk(clk), .rst_n(rst_v[3]), .en(en_v[3]), .din(din_v[3]), .clr_cnt(clr_v[3]),
    .match(m_3), .match_r(mr_3), .state(st_3), .match_cnt(cnt_3), .cnt_sat(sat_3));

  typedef struct {
    int id;
    int step;
    int st;
    int m;
    int mr;
    int cnt;
    int sat;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   step_no  = 0;

  task automatic check(string name, int step, int id, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s step=%0d inst=%0d got=%0d expected=%0d", name, step, id, act, exp);
    end
  endtask

  // Monitor: outputs of the addressed instance compared mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      int a_st, a_m, a_mr, a_cnt, a_sat;
      e = sb_q.pop_front();
      case (e.id)
        0:       begin a_st = int'(st_0); a_m = int'(m_0); a_mr = int'(mr_0); a_cnt = int'(cnt_0); a_sat = int'(sat_0); end
        1:       begin a_st = int'(st_1); a_m = int'(m_1); a_mr = int'(mr_1); a_cnt = int'(cnt_1); a_sat = int'(sat_1); end
        2:       begin a_st = int'(st_2); a_m = int'(m_2); a_mr = int'(mr_2); a_cnt = int'(cnt_2); a_sat = int'(sat_2); end
        default: begin a_st = int'(st_3); a_m = int'(m_3); a_mr = int'(mr_3); a_cnt = int'(cnt_3); a_sat = int'(sat_3); end
      endcase
      check("state",     e.step, e.id, a_st,  e.st);
      check("match",     e.step, e.id, a_m,   e.m);
      check("match_r",   e.step, e.id, a_mr,  e.mr);
      check("match_cnt", e.step, e.id, a_cnt, e.cnt);
      check("cnt_sat",   e.step, e.id, a_sat, e.sat);
      $display("step=%0d inst=%0d state=%0d match=%0d match_r=%0d cnt=%0d sat=%0d",
               e.step, e.id, a_st, a_m, a_mr, a_cnt, a_sat);
    end
  end

  // Drive one cycle on instance id (others idle) and queue its expected outputs.
  task automatic step(int id, bit r, bit e, bit d, bit c,
                      int es, int em, int emr, int ec, int esat);
    exp_t x;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      rst_v[i] = 1'b1; en_v[i] = 1'b0; din_v[i] = 1'b0; clr_v[i] = 1'b0;
    end
    rst_v[id] = r; en_v[id] = e; din_v[id] = d; clr_v[id] = c;
    step_no++;
    x = '{id: id, step: step_no, st: es, m: em, mr: emr, cnt: ec, sat: esat};
    sb_q.push_back(x);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog step=%0d got=timeout expected=finish", step_no);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      rst_v[i] = 1'b0; en_v[i] = 1'b0; din_v[i] = 1'b0; clr_v[i] = 1'b0;
    end
    repeat (2) @(posedge clk);

    // A: 1011 overlapping, stream 1,0,1,1,0,1,1
    //       id r e d c  st m mr cnt sat
    step(0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 2, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 3, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 1, 0, 1, 1, 0);
    step(0, 1, 1, 1, 0, 2, 0, 0, 1, 0);
    step(0, 1, 1, 1, 0, 3, 1, 0, 1, 0);
    step(0, 1, 0, 0, 0, 1, 0, 1, 2, 0);

    // B: same stream, non-overlapping
    step(1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 1, 0, 0, 0, 0);
    step(1, 1, 1, 1, 0, 2, 0, 0, 0, 0);
    step(1, 1, 1, 1, 0, 3, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0, 1, 1, 0);
    step(1, 1, 1, 1, 0, 0, 0, 0, 1, 0);
    step(1, 1, 1, 1, 0, 1, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0, 1, 0, 0, 1, 0);

    // C: 1101, stream 1,1,1,0,1 (mismatch in state 2 falls back to 2)
    step(2, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    step(2, 1, 1, 1, 0, 1, 0, 0, 0, 0);
    step(2, 1, 1, 1, 0, 2, 0, 0, 0, 0);
    step(2, 1, 1, 0, 0, 2, 0, 0, 0, 0);
    step(2, 1, 1, 1, 0, 3, 1, 0, 0, 0);
    step(2, 1, 0, 0, 0, 1, 0, 1, 1, 0);

    // D: reset u_a, then 1,0,1,1 with two en=0 cycles between bits
    step(0, 0, 0, 0, 0, 1, 0, 0, 2, 0);
    step(0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 2, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 2, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 2, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 3, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 3, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 3, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0, 1, 0, 1, 1, 0);
    step(0, 1, 0, 0, 0, 1, 0, 0, 1, 0);

    // E: CNT_W=2, five overlapping matches then clear coincident with a match
    step(3, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    step(3, 1, 1, 0, 0, 1, 0, 0, 0, 0);
    step(3, 1, 1, 1, 0, 2, 0, 0, 0, 0);
    step(3, 1, 1, 1, 0, 3, 1, 0, 0, 0);
    step(3, 1, 1, 0, 0, 1, 0, 1, 1, 0);
    step(3, 1, 1, 1, 0, 2, 0, 0, 1, 0);
    step(3, 1, 1, 1, 0, 3, 1, 0, 1, 0);
    step(3, 1, 1, 0, 0, 1, 0, 1, 2, 0);
    step(3, 1, 1, 1, 0, 2, 0, 0, 2, 0);
    step(3, 1, 1, 1, 0, 3, 1, 0, 2, 0);
    step(3, 1, 1, 0, 0, 1, 0, 1, 3, 1);
    step(3, 1, 1, 1, 0, 2, 0, 0, 3, 1);
    step(3, 1, 1, 1, 0, 3, 1, 0, 3, 1);
    step(3, 1, 1, 0, 0, 1, 0, 1, 3, 1);
    step(3, 1, 1, 1, 0, 2, 0, 0, 3, 1);
    step(3, 1, 1, 1, 0, 3, 1, 0, 3, 1);
    step(3, 1, 1, 0, 0, 1, 0, 1, 3, 1);
    step(3, 1, 1, 1, 0, 2, 0, 0, 3, 1);
    step(3, 1, 1, 1, 1, 3, 1, 0, 3, 1);
    step(3, 1, 0, 0, 0, 1, 0, 1, 1, 0);
    step(3, 1, 0, 0, 0, 1, 0, 0, 1, 0);

    // F: 1,0,1 then reset with en=1 din=1 in state 3, then din=1
    step(0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    step(0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 2, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 3, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    check("sb_drain", step_no, 0, sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
